// File: rtl/bmp_pixel_writer.sv
// Copies a rectangular source region into a byte-addressed BMP body:
// bottom-up rows, B,G,R byte order, rows zero-padded to a 4-byte multiple.
module bmp_pixel_writer #(
  parameter int SRC_WIDTH = 640,
  parameter int SRC_AW    = 19,
  parameter int HDR_BYTES = 54
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  input  logic [10:0]       xMin,
  input  logic [10:0]       xMax,
  input  logic [10:0]       yMin,
  input  logic [10:0]       yMax,
  output logic              src_rden,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [23:0]       src_rddata,
  output logic [23:0]       addr,
  output logic              wren,
  output logic [15:0]       wrdata
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // READ    | source read strobe for pixel (x,y)
  // WR_B    | write blue byte straight from read data, capture pixel
  // WR_G    | write green byte from pixel register
  // WR_R    | write red byte, advance x or finish the row's pixels
  // PAD     | write zero padding bytes at end of row
  // DONE    | copy finished (or bounds invalid), waiting for restart
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_B,
    S_WR_G,
    S_WR_R,
    S_PAD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] xmin_q, xmin_d;
  logic [10:0] xmax_q, xmax_d;
  logic [10:0] ymin_q, ymin_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [23:0] off_q, off_d;
  logic [1:0]  pad_q, pad_d;
  logic [1:0]  padcnt_q, padcnt_d;
  logic [23:0] pix_q, pix_d;
  logic        end_row;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      off_q    <= '0;
      pad_q    <= '0;
      padcnt_q <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      x_q      <= x_d;
      y_q      <= y_d;
      off_q    <= off_d;
      pad_q    <= pad_d;
      padcnt_q <= padcnt_d;
      pix_q    <= pix_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    x_d      = x_q;
    y_d      = y_q;
    off_d    = off_q;
    pad_d    = pad_q;
    padcnt_d = padcnt_q;
    pix_d    = pix_q;
    end_row  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          xmin_d   = xMin;
          xmax_d   = xMax;
          ymin_d   = yMin;
          x_d      = xMin;
          y_d      = yMax;
          off_d    = '0;
          padcnt_d = '0;
          // Only W mod 4 matters for padding: 3W + pad == 0 (mod 4).
          pad_d    = xMax[1:0] - xMin[1:0] + 2'd1;
          if ((xMax < xMin) || (yMax < yMin)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        state_d = S_WR_B;
      end

      S_WR_B: begin
        pix_d   = src_rddata;
        off_d   = off_q + 24'd1;
        state_d = S_WR_G;
      end

      S_WR_G: begin
        off_d   = off_q + 24'd1;
        state_d = S_WR_R;
      end

      S_WR_R: begin
        off_d = off_q + 24'd1;
        if (x_q < xmax_q) begin
          x_d     = x_q + 11'd1;
          state_d = S_READ;
        end else if (pad_q != 2'd0) begin
          state_d = S_PAD;
        end else begin
          end_row = 1'b1;
        end
      end

      S_PAD: begin
        off_d = off_q + 24'd1;
        if (padcnt_q == pad_q - 2'd1) begin
          padcnt_d = '0;
          end_row  = 1'b1;
        end else begin
          padcnt_d = padcnt_q + 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Rows are emitted bottom-up, so y walks from yMax down to yMin.
    if (end_row) begin
      if (y_q > ymin_q) begin
        y_d     = y_q - 11'd1;
        x_d     = xmin_q;
        state_d = S_READ;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_comb begin
    done     = (state_q == S_DONE);
    src_rden = (state_q == S_READ);
    src_addr = '0;
    wren     = 1'b0;
    wrdata   = '0;
    addr     = '0;

    if (state_q == S_READ) begin
      src_addr = SRC_AW'(y_q) * SRC_AW'(SRC_WIDTH) + SRC_AW'(x_q);
    end

    if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
      addr = 24'(HDR_BYTES) + off_q;
    end

    // Blue is forwarded from the read port since the pixel register
    // only captures it at the end of this same cycle.
    case (state_q)
      S_WR_B: begin
        wren   = 1'b1;
        wrdata = {8'h00, src_rddata[7:0]};
      end
      S_WR_G: begin
        wren   = 1'b1;
        wrdata = {8'h00, pix_q[15:8]};
      end
      S_WR_R: begin
        wren   = 1'b1;
        wrdata = {8'h00, pix_q[23:16]};
      end
      S_PAD: begin
        wren   = 1'b1;
        wrdata = 16'h0000;
      end
      default: begin
        wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bmp_pixel_writer.sv
// Directed bench for bmp_pixel_writer: a model fills write/read queues per
// region and a negedge monitor pops and compares every DUT strobe.
module tb_bmp_pixel_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic        src_rden;
  logic [18:0] src_addr;
  logic [23:0] src_rddata;
  logic [23:0] addr;
  logic        wren;
  logic [15:0] wrdata;

  int vecs = 0;
  int errs = 0;
  int n_wr = 0;
  int n_rd = 0;
  bit sb_en = 1'b1;

  logic [39:0] wq[$];
  logic [18:0] rq[$];

  bmp_pixel_writer #(.SRC_WIDTH(640), .SRC_AW(19), .HDR_BYTES(54)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .src_rden(src_rden), .src_addr(src_addr), .src_rddata(src_rddata),
    .addr(addr), .wren(wren), .wrdata(wrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix_of(input logic [18:0] a);
    if (a == 19'd0) return 24'h112233;
    return {a[7:0] ^ 8'h3C, a[15:8] + 8'h11, a[18:16], a[4:0]};
  endfunction

  always @(posedge clk) begin
    src_rddata <= src_rden ? pix_of(src_addr) : 24'hDEAD00;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wren) n_wr++;
    if (src_rden) n_rd++;
    if (sb_en && wren) begin
      if (wq.size() == 0) begin
        errs++;
        $error("FAIL wr_unexpected: got addr %0h data %0h want no write", addr, wrdata);
      end else begin
        chk("wr_addr_data", {24'h0, addr, wrdata}, {24'h0, wq.pop_front()});
      end
    end
    if (sb_en && src_rden) begin
      if (rq.size() == 0) begin
        errs++;
        $error("FAIL rd_unexpected: got src_addr %0h want no read", src_addr);
      end else begin
        chk("rd_addr", {45'h0, src_addr}, {45'h0, rq.pop_front()});
      end
    end
  end

  task automatic push_region(input int x0, input int x1, input int y0, input int y1);
    int off;
    int pad;
    logic [31:0] la;
    logic [18:0] a;
    logic [23:0] p;
    logic [23:0] ba;
    off = 0;
    pad = (x1 - x0 + 1) & 3;
    if (x1 < x0 || y1 < y0) return;
    for (int y = y1; y >= y0; y--) begin
      for (int x = x0; x <= x1; x++) begin
        la = 32'(y * 640 + x);
        a  = la[18:0];
        rq.push_back(a);
        p  = pix_of(a);
        ba = 24'(54 + off);
        wq.push_back({ba, 8'h00, p[7:0]});
        wq.push_back({ba + 24'd1, 8'h00, p[15:8]});
        wq.push_back({ba + 24'd2, 8'h00, p[23:16]});
        off += 3;
      end
      for (int k = 0; k < pad; k++) begin
        wq.push_back({24'(54 + off), 16'h0000});
        off++;
      end
    end
  endtask

  task automatic run_region(input string tag, input int x0, input int x1,
                            input int y0, input int y1, input bit poke);
    int w, h, pad, exp_cyc, exp_wr, exp_rd, wr0, rd0, cyc;
    w = x1 - x0 + 1;
    h = y1 - y0 + 1;
    pad = w & 3;
    if (x1 < x0 || y1 < y0) begin
      exp_cyc = 1; exp_wr = 0; exp_rd = 0;
    end else begin
      exp_cyc = h * (4 * w + pad) + 1;
      exp_wr  = h * (3 * w + pad);
      exp_rd  = h * w;
    end
    push_region(x0, x1, y0, y1);
    xMin = 11'(x0); xMax = 11'(x1); yMin = 11'(y0); yMax = 11'(y1);
    start = 1'b1;
    wr0 = n_wr; rd0 = n_rd;
    @(posedge clk);
    #1;
    start = 1'b0;
    xMin = 11'd7; xMax = 11'd1; yMin = 11'd9; yMax = 11'd3;
    cyc = 1;
    while (!done && cyc < 40000) begin
      if (poke && (cyc % 7 == 3) && (cyc + 2 < exp_cyc)) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    #1;
    chk({tag, "_wr_count"}, 64'(n_wr - wr0), 64'(exp_wr));
    chk({tag, "_rd_count"}, 64'(n_rd - rd0), 64'(exp_rd));
    chk({tag, "_wq_left"}, 64'(wq.size()), 64'd0);
    chk({tag, "_rq_left"}, 64'(rq.size()), 64'd0);
    chk({tag, "_done_hold"}, {63'h0, done}, 64'd1);
  endtask

  initial begin
    int wr0;
    rst_n = 1'b0;
    start = 1'b1;
    xMin = 11'd0; xMax = 11'd3; yMin = 11'd0; yMax = 11'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_outputs", {done, wren, src_rden, addr, wrdata, src_addr},
        {1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 19'h0});
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", {60'h0, done, wren, src_rden, |addr}, 64'd0);

    run_region("px1x1", 0, 0, 0, 0, 1'b0);
    run_region("r4x2", 2, 5, 10, 11, 1'b0);
    run_region("r3x2", 0, 2, 0, 1, 1'b0);
    run_region("r2x1_edge", 2046, 2047, 5, 5, 1'b0);
    run_region("px_far", 2047, 2047, 2047, 2047, 1'b0);
    run_region("bad_x", 5, 4, 0, 0, 1'b0);
    run_region("bad_y", 0, 3, 6, 5, 1'b0);
    run_region("r5x3_poke", 7, 11, 20, 22, 1'b1);
    run_region("r3x2_again", 0, 2, 0, 1, 1'b0);

    // Abort mid-row: writes must stop the cycle after reset is sampled.
    sb_en = 1'b0;
    xMin = 11'd0; xMax = 11'd3; yMin = 11'd0; yMax = 11'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_outputs", {done, wren, src_rden, addr, wrdata, src_addr},
        {1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 19'h0});
    rst_n = 1'b1;
    wr0 = n_wr;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_writes", 64'(n_wr - wr0), 64'd0);
    chk("abort_idle", {63'h0, done}, 64'd0);
    wq.delete();
    rq.delete();
    sb_en = 1'b1;
    run_region("after_abort", 1, 2, 3, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bmp_pixel_writer.md
# bmp_pixel_writer

Downstream companion to the BMP header stage. Once the 54-byte header is in the output memory, this block copies the pixel body for a rectangular region of the source frame buffer into the same byte-addressed memory. The region is bounded by xMin..xMax and yMin..yMax. Output follows BMP layout: bottom-up rows, B,G,R byte order, and each row zero-padded to a multiple of 4 bytes.

## Interface
- SRC_WIDTH, 640: source frame width in pixels, used for the row stride.
- SRC_AW, 19: source address width.
- HDR_BYTES, 54: byte offset of the first pixel byte in the output memory.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a copy; sampled only in IDLE and DONE.
- done  out  1  high while in DONE.
- xMin, xMax, yMin, yMax  in  11 each  inclusive region bounds, unsigned.
- src_rden  out  1  source read strobe.
- src_addr  out  SRC_AW  source pixel address: y*SRC_WIDTH + x, truncated to SRC_AW bits.
- src_rddata  in  24  {R[23:16], G[15:8], B[7:0]}, valid exactly 1 cycle after src_rden.
- addr  out  24  output byte address.
- wren  out  1  output write strobe, one byte per cycle.
- wrdata  out  16  byte in [7:0]; [15:8] always 0.

## Operation
- States: IDLE, READ, WR_B, WR_G, WR_R, PAD, DONE.
- Start in IDLE or DONE:
  - Latch all four bounds.
  - Set x=xMin, y=yMax, byte counter off=0, padcnt=0.
  - Compute W=xMax-xMin+1 and pad=W[1:0]; this is the padding, since 3W+pad ≡ 0 mod 4.
  - Go to READ.
- Invalid bounds (xMax<xMin or yMax<yMin) at start: go directly to DONE with no reads or writes.
- READ: src_rden=1, src_addr=y*SRC_WIDTH+x. Next state WR_B.
- WR_B: capture src_rddata into a pixel register. Write B at HDR_BYTES+off, off++. Next state WR_G.
- WR_G: write G, off++. Next state WR_R.
- WR_R: write R, off++. Next state:
  - x<xMax: x++, go to READ.
  - otherwise, pad≠0: go to PAD.
  - otherwise: end of row.
- PAD: write 0x00, off++, padcnt++. When padcnt reaches pad-1 in this cycle, clear padcnt and end the row.
- End of row:
  - y>yMin: y--, x=xMin, go to READ.
  - otherwise go to DONE.
- DONE: done=1, all strobes 0.
  - start=1 restarts exactly as from IDLE and relatches the bounds.
  - Otherwise stay in DONE.
- start is ignored in READ..PAD; bounds changing mid-copy have no effect.
- Arithmetic:
  - off is 24 bits. Maximum body is 2048×(3·2048+3) bytes, which is below 2^24, so off never wraps.
  - addr = HDR_BYTES + off, modulo 2^24.
- Outputs are Moore-decoded from registered state, counters and the pixel register.
- In IDLE and DONE: addr=0, wrdata=0, src_addr=0.

## Timing
- Reset, in the cycle after rst_n=0 is sampled: state IDLE, done=0, wren=0, src_rden=0, addr=0, wrdata=0, src_addr=0. All counters are cleared.
- Reset mid-copy aborts immediately. The next cycle shows IDLE values and no further writes occur.
- start sampled at edge k: READ is active in cycle k+1, first wren in cycle k+2.
- Each pixel takes 4 cycles: 1 read plus 3 writes. Each row adds pad cycles.
- Total active cycles: H·(4W+pad), where H=yMax-yMin+1.
- done rises in the cycle after the last write.
- wren is never high in READ, IDLE or DONE. src_rden is high only in READ.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with start=1 → all outputs 0 and done=0; after release, stays IDLE until start.
- 1×1 region at (0,0), src[0]=0x112233:
  - 1 read at src_addr 0.
  - Writes (54,0x33), (55,0x22), (56,0x11), (57,0x00).
  - done rises 6 cycles after the start edge.
- 4×2 region x=2..5, y=10..11, pad 0:
  - 24 writes at addrs 54..77.
  - First read at src_addr 11·640+2=7042; last read at 6405.
  - No PAD cycles.
- 3×2 region: each row is 9 pixel bytes followed by 3 zero bytes. Rows start at 54 and 66; final write at addr 77.
- Invalid bounds xMin=5, xMax=4 → done rises 1 cycle after start with zero wren and zero src_rden pulses.
- Restart and abort:
  - start pulses mid-copy are ignored, and the byte stream is unchanged.
  - start in DONE with a new region repeats the copy from addr 54.
  - rst_n=0 mid-row stops writes at once, and the next start begins at addr 54.
